// File: rtl/ring_osc_meas_pkg.sv
// Shared types and helpers for the ring oscillator measurement controller.
package ring_osc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchroniser for the asynchronous ring output plus a delay flop
// for rising-edge detection in the clk domain.
module ro_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ro_out,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= ro_out;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign rise = sync2 & ~sync_d;

endmodule

// File: rtl/ring_osc_meas_ctrl.sv
// Enables the ring oscillator, lets it settle, counts its rising edges over a
// programmable gate window and reports the saturating count with a done pulse.
module ring_osc_meas_ctrl
    import ring_osc_meas_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_W        = 12,
    parameter int CNT_W         = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_out,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int TMR_W = max_int($clog2(SETTLE_CYCLES + 1), GATE_W);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [GATE_W-1:0] gate_q;
    logic [TMR_W-1:0]  tmr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_acc;
    logic              edge_rise;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;

    ro_edge_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .ro_out (ro_out),
        .rise   (edge_rise)
    );

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf_acc;
        if (state == MEASURE && edge_rise) begin
            if (cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gate_q   <= '0;
            tmr      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            ro_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
            ro_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        gate_q  <= gate_cycles;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        tmr     <= SETTLE_LOAD;
                        state   <= SETTLE;
                        ro_en   <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (tmr == '0) begin
                        if (gate_q == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            ro_en    <= 1'b0;
                            count    <= cnt;
                            overflow <= ovf_acc;
                        end else begin
                            state <= MEASURE;
                            tmr   <= TMR_W'(gate_q) - 1'b1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                MEASURE: begin
                    cnt     <= cnt_nxt;
                    ovf_acc <= ovf_nxt;
                    // The edge seen in the last gate cycle still belongs to the result.
                    if (tmr == '0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        ro_en    <= 1'b0;
                        count    <= cnt_nxt;
                        overflow <= ovf_nxt;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ro_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_meas_ctrl.sv
// Directed bench for ring_osc_meas_ctrl with a clk-locked ring model.
module tb_ring_osc_meas_ctrl;

    localparam int SETTLE = 16;
    localparam int GW     = 12;
    localparam int CW     = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [GW-1:0] gate_cycles;
    logic          ro_out;
    logic          ro_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    int ro_half = 4;
    bit ro_run  = 1'b0;
    int ro_ph   = 0;

    ring_osc_meas_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .GATE_W        (GW),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .gate_cycles (gate_cycles),
        .ro_out      (ro_out),
        .ro_en       (ro_en),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Ring toggles on the falling clk edge so its sampled pattern is strictly periodic.
    always @(negedge clk) begin
        if (ro_run) begin
            ro_ph = ro_ph + 1;
            if (ro_ph >= ro_half) begin
                ro_ph  = 0;
                ro_out = ~ro_out;
            end
        end
    end

    task automatic set_ring(input int half);
        ro_half = half;
        ro_ph   = 0;
        ro_run  = 1'b1;
    endtask

    task automatic start_meas(input int g);
        gate_cycles = GW'(g);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                cyc  = i + 2;
            end
        end
    endtask

    task automatic expect_done(input string name, input int exp_cyc, input int cmin,
                               input int cmax, input logic exp_ovf);
        int cyc;
        bit seen;
        wait_done(cyc, seen);
        total++;
        if (!seen || cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s_done_cycle: got %0d (seen=%0b) want %0d", name, cyc, seen, exp_cyc);
        end
        total++;
        if (int'(count) < cmin || int'(count) > cmax) begin
            bad++;
            $display("FAIL %s_count: got %0d want %0d..%0d", name, count, cmin, cmax);
        end
        total++;
        if (overflow !== exp_ovf) begin
            bad++;
            $display("FAIL %s_overflow: got %b want %b", name, overflow, exp_ovf);
        end
        total++;
        if (ro_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s_done_flags: got ro_en=%b busy=%b want ro_en=0 busy=1", name, ro_en, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_after_done: got done=%b busy=%b want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        gate_cycles = GW'(5);
        ro_out = 1'b0;
        set_ring(2);
        repeat (5) @(posedge clk);
        #1;
        total++;
        if ({ro_en, busy, done, count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got ro_en=%b busy=%b done=%b count=%0d ovf=%b want all 0",
                     ro_en, busy, done, count, overflow);
        end
        start = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ro_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got ro_en=%b busy=%b want 0 0", ro_en, busy);
        end
    endtask

    task automatic test_basic();
        set_ring(4);
        start_meas(64);
        gate_cycles = GW'(5);
        total++;
        if (ro_en !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_start_flags: got ro_en=%b busy=%b want 1 1", ro_en, busy);
        end
        expect_done("basic", 81, 7, 9, 1'b0);
    endtask

    task automatic test_gate_zero();
        set_ring(1);
        start_meas(0);
        expect_done("gate0", 17, 0, 0, 1'b0);
    endtask

    task automatic test_saturate();
        set_ring(2);
        start_meas(200);
        expect_done("sat", 217, 15, 15, 1'b1);
        set_ring(16);
        start_meas(64);
        expect_done("slow", 81, 2, 2, 1'b0);
    endtask

    task automatic test_abort();
        int dones = 0;
        set_ring(2);
        start_meas(64);
        repeat (26) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        total++;
        if (busy !== 1'b0 || ro_en !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b ro_en=%b done=%b want 0 0 0", busy, ro_en, done);
        end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || count !== CW'(2) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL abort_result_kept: got dones=%0d count=%0d ovf=%b want 0 2 0", dones, count, overflow);
        end
        start = 1'b1;
        abort = 1'b1;
        gate_cycles = GW'(3);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || ro_en !== 1'b0) begin
            bad++;
            $display("FAIL start_abort_same: got busy=%b ro_en=%b want 0 0", busy, ro_en);
        end
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        gate_cycles = GW'(0);
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++;
        if (dones != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_held_retrigger: got dones=%0d busy=%b want 2 0", dones, busy);
        end
    endtask

    task automatic test_busy_and_reset();
        int dones = 0;
        set_ring(4);
        start_meas(64);
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_while_busy: got dones=%0d busy=%b want 1 0", dones, busy);
        end
        start_meas(64);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ro_en, busy, done, count, overflow} !== '0) begin
            bad++;
            $display("FAIL reset_mid_measure: got ro_en=%b busy=%b done=%b count=%0d ovf=%b want all 0",
                     ro_en, busy, done, count, overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_meas(64);
        expect_done("post_reset", 81, 7, 9, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gate_zero();
        test_saturate();
        test_abort();
        test_back_to_back();
        test_busy_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
